pll_reset_ctrl: RTL
===================

Name: pll_reset_ctrl

Overview:
Reset and lock sequencer for the video-clock PLL. Runs on the free-running 50 MHz reference clock, drives the PLL reset with a guaranteed minimum pulse, and waits for a debounced lock. It then releases the downstream system reset for the 25.2 MHz pixel and 1.23 MHz I2C domains. It retries on lock timeout, re-sequences on loss of lock, and latches a failure state after retries are exhausted.

Parameters:
RST_PULSE_CYCLES, 16, refclk cycles pll_rst is held high per attempt (>=1)
LOCK_TIMEOUT_CYCLES, 50000, refclk cycles allowed from pll_rst release to entering RUN (1 ms)
LOCK_STABLE_CYCLES, 1024, consecutive synchronized-lock-high cycles required before RUN (>=1)
MAX_RETRIES, 3, PLL re-reset attempts after a timeout before FAIL (>=0)

Ports:
refclk  input  1  reference clock, 50 MHz, sole clock of block
rst  input  1  synchronous active-high reset
pll_locked  input  1  raw PLL lock, asynchronous to refclk
pll_rst  output  1  drives PLL rst, active-high
sys_rst  output  1  downstream reset, active-high, synchronous to refclk
ready  output  1  high only in RUN
fail  output  1  high only in FAIL
state  output  3  current FSM state encoding
retry_cnt  output  $clog2(MAX_RETRIES+1) (min 1)  timeouts in current sequence
lock_loss_cnt  output  8  lock-loss events (see Optional Feature)

Behaviour:
- All outputs registered. On rst (sampled at refclk edge): state=RESET, pll_rst=1, sys_rst=1, ready=0, fail=0, retry_cnt=0, lock_loss_cnt=0, all internal counters and sync flops 0. rst mid-operation aborts any state, FAIL included, identically.
- pll_locked passes through a 2-flop synchronizer -> lock_s. 2-cycle latency, no other filtering.
- State encodings: RESET=0, WAIT_LOCK=1, STABLE=2, RUN=3, FAIL=4. Unused codes -> RESET next cycle.
- RESET: pll_rst=1, sys_rst=1. Pulse counter counts RST_PULSE_CYCLES cycles after rst deasserts or after state entry. Then -> WAIT_LOCK; timeout counter cleared on this transition.
- WAIT_LOCK: pll_rst=0, sys_rst=1. Timeout counter increments every cycle. lock_s=1 -> STABLE, stable counter cleared.
- STABLE: pll_rst=0, sys_rst=1. Timeout counter keeps running. Stable counter increments while lock_s=1. lock_s=0 -> WAIT_LOCK, stable counter cleared. Stable count reaching LOCK_STABLE_CYCLES -> RUN.
- Timeout in WAIT_LOCK or STABLE: when the timeout counter reaches LOCK_TIMEOUT_CYCLES, the timeout check takes priority over the stable-complete check in the same cycle.
  - retry_cnt==MAX_RETRIES -> FAIL.
  - Otherwise retry_cnt+1 -> RESET.
- RUN: pll_rst=0, sys_rst=0, ready=1. retry_cnt cleared on entry. lock_s=0 -> RESET, lock_loss_cnt+1 (saturating at 255), ready and sys_rst change on the next edge.
- FAIL: pll_rst=1, sys_rst=1, fail=1. Only rst exits.
- Minimum lock-to-ready latency from lock_s rise: LOCK_STABLE_CYCLES+1 refclk cycles. pll_locked to lock_s adds 2.
- Counters sized by $clog2 of their parameter+1. No wrap is possible, since each counter resets at its terminal value.

Optional Feature:
PLL_LOCK_LOSS_COUNT_EN:
- Defined: lock_loss_cnt implemented as above.
- Undefined: counter logic omitted, lock_loss_cnt tied to 0. Port list and every other behaviour unchanged.

Test Plan:
Bench parameters: RST_PULSE_CYCLES=4, LOCK_TIMEOUT_CYCLES=100, LOCK_STABLE_CYCLES=8, MAX_RETRIES=2, macro defined.
- Reset release, pll_locked rises 10 cycles after pll_rst falls -> pll_rst high exactly 4 cycles after rst drop; sys_rst falls and ready rises 2+8+1 cycles after pll_locked rise; state=3, retry_cnt=0.
- pll_locked held 0 -> 3 pll_rst pulses of 4 cycles spaced 100 cycles apart; retry_cnt 0->1->2; after third timeout state=4, fail=1, pll_rst=1, sys_rst=1 persist 1000 cycles.
- pll_locked glitches high 5 cycles, low 1 cycle, then steady high -> STABLE->WAIT_LOCK->STABLE; RUN only after 8 consecutive high lock_s cycles.
- In RUN, drop pll_locked for 1 cycle -> 2 cycles later state=RESET, sys_rst=1, ready=0, lock_loss_cnt=1; relock returns to RUN with retry_cnt=0.
- Assert rst during STABLE and during FAIL -> all outputs at reset values next cycle; full sequence restarts.
- Macro undefined, repeat lock-loss test -> lock_loss_cnt stays 0; all other responses identical.

Source files
------------

// File: rtl/pll_reset_ctrl.sv
// Video-clock PLL reset/lock sequencer on the 50 MHz refclk: PLL reset pulse, debounced lock, retries, FAIL latch.
// Define PLL_LOCK_LOSS_COUNT_EN to implement lock_loss_cnt; otherwise the port is tied to zero.
module pll_reset_ctrl #(
  parameter int RST_PULSE_CYCLES    = 16,
  parameter int LOCK_TIMEOUT_CYCLES = 50000,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int MAX_RETRIES         = 3,
  localparam int RW = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1
) (
  input  logic          refclk,
  input  logic          rst,
  input  logic          pll_locked,
  output logic          pll_rst,
  output logic          sys_rst,
  output logic          ready,
  output logic          fail,
  output logic [2:0]    state,
  output logic [RW-1:0] retry_cnt,
  output logic [7:0]    lock_loss_cnt
);

  // state     | meaning
  // RESET     | PLL held in reset for the pulse length
  // WAIT_LOCK | waiting for synchronized lock
  // STABLE    | counting consecutive lock cycles
  // RUN       | downstream reset released
  // FAIL      | retries exhausted, only rst exits
  typedef enum logic [2:0] {
    S_RESET  = 3'd0,
    S_WAIT   = 3'd1,
    S_STABLE = 3'd2,
    S_RUN    = 3'd3,
    S_FAIL   = 3'd4
  } state_t;

  localparam int PW = $clog2(RST_PULSE_CYCLES + 1);
  localparam int TW = $clog2(LOCK_TIMEOUT_CYCLES + 1);
  localparam int SW = $clog2(LOCK_STABLE_CYCLES + 1);

  localparam logic [PW-1:0] PULSE_LAST = PW'(RST_PULSE_CYCLES - 1);
  localparam logic [TW-1:0] TO_LAST    = TW'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [SW-1:0] STB_LAST   = SW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [RW-1:0] RETRY_MAX  = RW'(MAX_RETRIES);

  state_t        state_q, state_d;
  logic [PW-1:0] pulse_cnt_q, pulse_cnt_d;
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic [SW-1:0] stb_cnt_q, stb_cnt_d;
  logic [RW-1:0] retry_q, retry_d;
  logic          sync1_q, lock_s_q;
  logic          pll_rst_q, pll_rst_d;
  logic          sys_rst_q, sys_rst_d;
  logic          ready_q, ready_d;
  logic          fail_q, fail_d;
`ifdef PLL_LOCK_LOSS_COUNT_EN
  logic [7:0]    loss_q, loss_d;
`endif

  always_comb begin
    state_d     = state_q;
    pulse_cnt_d = pulse_cnt_q;
    to_cnt_d    = to_cnt_q;
    stb_cnt_d   = stb_cnt_q;
    retry_d     = retry_q;
`ifdef PLL_LOCK_LOSS_COUNT_EN
    loss_d      = loss_q;
`endif
    case (state_q)
      S_RESET: begin
        if (pulse_cnt_q == PULSE_LAST) begin
          state_d     = S_WAIT;
          pulse_cnt_d = '0;
          to_cnt_d    = '0;
        end else begin
          pulse_cnt_d = pulse_cnt_q + 1'b1;
        end
      end
      S_WAIT, S_STABLE: begin
        // timeout wins over any lock decision taken in the same cycle
        if (to_cnt_q == TO_LAST) begin
          to_cnt_d  = '0;
          stb_cnt_d = '0;
          if (retry_q == RETRY_MAX) begin
            state_d = S_FAIL;
          end else begin
            retry_d     = retry_q + 1'b1;
            state_d     = S_RESET;
            pulse_cnt_d = '0;
          end
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
          if (state_q == S_WAIT) begin
            if (lock_s_q) begin
              state_d   = S_STABLE;
              stb_cnt_d = '0;
            end
          end else if (!lock_s_q) begin
            state_d   = S_WAIT;
            stb_cnt_d = '0;
          end else if (stb_cnt_q == STB_LAST) begin
            state_d   = S_RUN;
            stb_cnt_d = '0;
            retry_d   = '0;
          end else begin
            stb_cnt_d = stb_cnt_q + 1'b1;
          end
        end
      end
      S_RUN: begin
        if (!lock_s_q) begin
          state_d     = S_RESET;
          pulse_cnt_d = '0;
`ifdef PLL_LOCK_LOSS_COUNT_EN
          if (loss_q != 8'hFF) loss_d = loss_q + 8'd1;
`endif
        end
      end
      S_FAIL: begin
        state_d = S_FAIL;
      end
      default: begin
        state_d     = S_RESET;
        pulse_cnt_d = '0;
        to_cnt_d    = '0;
        stb_cnt_d   = '0;
      end
    endcase

    pll_rst_d = (state_d == S_RESET) || (state_d == S_FAIL);
    sys_rst_d = (state_d != S_RUN);
    ready_d   = (state_d == S_RUN);
    fail_d    = (state_d == S_FAIL);
  end

  always_ff @(posedge refclk) begin
    if (rst) begin
      state_q     <= S_RESET;
      pulse_cnt_q <= '0;
      to_cnt_q    <= '0;
      stb_cnt_q   <= '0;
      retry_q     <= '0;
      sync1_q     <= 1'b0;
      lock_s_q    <= 1'b0;
      pll_rst_q   <= 1'b1;
      sys_rst_q   <= 1'b1;
      ready_q     <= 1'b0;
      fail_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      pulse_cnt_q <= pulse_cnt_d;
      to_cnt_q    <= to_cnt_d;
      stb_cnt_q   <= stb_cnt_d;
      retry_q     <= retry_d;
      sync1_q     <= pll_locked;
      lock_s_q    <= sync1_q;
      pll_rst_q   <= pll_rst_d;
      sys_rst_q   <= sys_rst_d;
      ready_q     <= ready_d;
      fail_q      <= fail_d;
    end
  end

`ifdef PLL_LOCK_LOSS_COUNT_EN
  always_ff @(posedge refclk) begin
    if (rst) loss_q <= 8'd0;
    else     loss_q <= loss_d;
  end
  assign lock_loss_cnt = loss_q;
`else
  assign lock_loss_cnt = 8'd0;
`endif

  assign pll_rst   = pll_rst_q;
  assign sys_rst   = sys_rst_q;
  assign ready     = ready_q;
  assign fail      = fail_q;
  assign state     = state_q;
  assign retry_cnt = retry_q;

endmodule
